// File: rtl/mem_stage.sv
// MEM stage with MEM_WB pipeline register: branch resolve, word-addressed data memory with
// MEM_LAT-cycle access and upstream stall. Optional misaligned-access trap: MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcIn,
  input  logic        zeroIn,
  input  logic [31:0] ALUOutIn,
  input  logic [31:0] readData2In,
  input  logic [4:0]  regFromMuxIn,
  input  logic [1:0]  WBIn,
  input  logic        branchIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  output logic        pcSrcOut,
  output logic [31:0] branchTargetOut,
  output logic        stallOut,
  output logic [31:0] readDataOut,
  output logic [31:0] ALUOutOut,
  output logic [4:0]  regFromMuxOut,
  output logic [1:0]  WBOut,
  output logic        misalignOut
);

  localparam int                CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0]        mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]  index;
  logic               req, misaligned, access, complete, write_en, stall_raw;

  logic [31:0]        read_data_q, read_data_d;
  logic [31:0]        alu_out_q, alu_out_d;
  logic [4:0]         reg_q, reg_d;
  logic [1:0]         wb_q, wb_d;
  logic               misalign_q, misalign_d;

  assign pcSrcOut        = branchIn & zeroIn;
  assign branchTargetOut = pcIn;

  // Upper ALU bits are dropped so addresses wrap within the memory depth.
  assign index = ALUOutIn[ADDR_W+1:2];
  assign req   = memReadIn | memWriteIn;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = req & (ALUOutIn[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign access = req & ~misaligned;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    complete  = 1'b0;
    if (MEM_LAT == 1) begin
      complete = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            stall_raw = 1'b1;
            state_d   = BUSY;
            cnt_d     = CNT_INIT;
          end else begin
            complete = 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q > CNT_ONE) begin
            stall_raw = 1'b1;
            cnt_d     = cnt_q - CNT_ONE;
          end else begin
            complete = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Reset aborts a pending access at once: no stall, no late store.
  assign stallOut = stall_raw & ~reset;
  assign write_en = complete & memWriteIn & ~misaligned & ~reset;

  always_comb begin
    read_data_d = '0;
    alu_out_d   = '0;
    reg_d       = '0;
    wb_d        = '0;
    misalign_d  = 1'b0;
    if (complete) begin
      if (memReadIn && !misaligned) read_data_d = mem[index];
      alu_out_d  = ALUOutIn;
      reg_d      = regFromMuxIn;
      wb_d       = {WBIn[1] & ~misaligned, WBIn[0]};
      misalign_d = misaligned;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
      alu_out_q   <= '0;
      reg_q       <= '0;
      wb_q        <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      alu_out_q   <= alu_out_d;
      reg_q       <= reg_d;
      wb_q        <= wb_d;
      misalign_q  <= misalign_d;
    end
  end

  // NOTE: the data memory has no reset; its contents survive a pipeline reset.
  always_ff @(negedge clk) begin
    if (write_en) mem[index] <= readData2In;
  end

  assign readDataOut   = read_data_q;
  assign ALUOutOut     = alu_out_q;
  assign regFromMuxOut = reg_q;
  assign WBOut         = wb_q;
  assign misalignOut   = misalign_q;

endmodule
